// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a one-entry
// holding register to decode, and redirect handling. Optional MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
`ifdef MISALIGN_TRAP_EN
  output logic        trap,
`endif
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        capture;
  logic [31:0] redir_tgt;
  logic        trap_nxt;

`ifdef MISALIGN_TRAP_EN
  assign redir_tgt = (redir_pc[1:0] != 2'b00) ? TRAP_PC : redir_pc;
  assign trap_nxt  = redir_valid && (redir_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];
  assign redir_tgt = {redir_pc[31:2], 2'b00};
  assign trap_nxt  = 1'b0;
`endif

  // Redirect is evaluated first in every state so it always wins.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    capture   = 1'b0;
    if (redir_valid) begin
      pc_nxt = redir_tgt;
      case (state)
        REQ: begin
          if (imem_gnt) begin
            drop_nxt  = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            drop_nxt  = 1'b1;
            state_nxt = WAIT;
          end
        end
        default: state_nxt = REQ;
      endcase
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (imem_gnt) state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              capture   = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      if_valid  <= 1'b0;
      if_instr  <= 32'h0;
      if_pc     <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      trap      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      imem_req  <= (state_nxt == REQ);
      imem_addr <= (state_nxt == REQ) ? pc_nxt : 32'h0;
      if_valid  <= (state_nxt == HOLD);
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
`ifdef MISALIGN_TRAP_EN
      trap      <= trap_nxt;
`endif
    end
  end

`ifndef MISALIGN_TRAP_EN
  logic unused_trap;
  assign unused_trap = trap_nxt;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_PC, default 32'h0000_0004, giving the misaligned-redirect trap vector.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: read data valid.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction.
REQ-010 The block SHALL have port if_valid, output, 1 bit: instruction valid to decode.
REQ-011 The block SHALL have port if_instr, output, 32 bits: held instruction.
REQ-012 The block SHALL have port if_pc, output, 32 bits: PC of the held instruction.
REQ-013 The block SHALL have port id_ready, input, 1 bit: decode accepts the held instruction.
REQ-014 The block SHALL have port redir_valid, input, 1 bit: execute stage resolved a taken branch/jump this cycle.
REQ-015 The block SHALL have port redir_pc, input, 32 bits: redirect target, the next-PC mux output.
REQ-016 The block SHALL have port trap, output, 1 bit: misaligned-redirect pulse, present only with the macro of REQ-031.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, plus an internal pc register and a drop flag.
REQ-018 IDLE: all outputs inactive; SHALL go to REQ on the first clk edge after rst deasserts.
REQ-019 REQ: imem_req=1 and imem_addr=pc; on imem_gnt go to WAIT; imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0.
REQ-020 WAIT: on imem_rvalid with drop=0, capture if_instr<=imem_rdata and if_pc<=pc, then go to HOLD; fetch latency is gnt+1 cycles minimum.
REQ-021 HOLD: if_valid=1 with if_instr and if_pc stable; on id_ready, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), then go to REQ.
REQ-022 if_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in REQ; at most one request SHALL be outstanding.
REQ-023 redir_valid SHALL have priority over every other event in every state; on it, pc<=redir_pc.
REQ-024 Redirect in REQ without imem_gnt: go to REQ with the new pc; the next cycle presents the new address.
REQ-025 Redirect in REQ with imem_gnt, or in WAIT without imem_rvalid: set drop=1 and go to WAIT.
REQ-026 WAIT with drop=1 and imem_rvalid: discard the data, clear drop, go to REQ.
REQ-027 Redirect in WAIT coinciding with imem_rvalid: discard the data, drop=0, go to REQ.
REQ-028 Redirect in HOLD: discard the held instruction regardless of id_ready; if_valid=0 next cycle; go to REQ.
REQ-029 A repeated redirect while drop=1 SHALL only update pc.

Reset
REQ-030 While rst=1: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, trap=0; asserting rst mid-fetch SHALL abandon the transaction, and a late imem_rvalid in IDLE SHALL be ignored.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined, a redirect with redir_pc[1:0]!=0 SHALL load pc<=TRAP_PC and pulse trap=1 for one cycle; all other redirect handling is unchanged. Without the macro, the trap port SHALL be absent and pc<={redir_pc[31:2],2'b00}.

Verification
REQ-032 Reset release, imem_gnt=1, imem_rvalid one cycle later with 0x00000013, id_ready=1 -> imem_addr 0x0,0x4,0x8; if_pc 0x0 with if_instr 0x00000013.
REQ-033 imem_gnt held 0 for 3 cycles at pc 0x10 -> imem_addr stays 0x10 and imem_req stays 1 until grant.
REQ-034 redir_valid with redir_pc=0x200 in WAIT, response arrives 2 cycles later -> response dropped, if_valid stays 0, next imem_addr=0x200.
REQ-035 HOLD with id_ready=1 and redir_valid=1 (redir_pc=0x40) in the same cycle -> instruction discarded, next fetch 0x40, not pc+4.
REQ-036 MISALIGN_TRAP_EN defined, redir_pc=0x102 -> trap high for 1 cycle, next imem_addr=0x4; without the macro -> next imem_addr=0x100.
